interrupt_sequencer: RTL

Multi-cycle controller that sequences interrupt entry and RTI return for the five-stage pipeline.
- On an accepted interrupt it freezes fetch and injects NOPs through the CU mux, then drains in-flight instructions.
- It then drives the memory stage's push path (counter value + int signal) to save PC and CCR, and finally loads the vector into the PC.
- On RTI it pops CCR and PC back and resumes.
- It sits beside the HDU: its freeze/NOP outputs are OR-ed into reg_fetch_decode enable and the cu_mux selector.

---
 rtl/interrupt_sequencer_if.sv | 36 +++
 rtl/interrupt_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer_if.sv
// Pipeline-facing bundle of the interrupt sequencer: request/qualifier inputs,
// stack push/pop strobes and PC/CCR override outputs.
interface interrupt_sequencer_if;
    logic        int_req;
    logic        hdu_stall;
    logic        branch_pending;
    logic        rti_decode;
    logic [31:0] pc_fetch;
    logic [2:0]  ccr_in;
    logic [15:0] pop_data;

    logic        int_ack;
    logic        in_isr;
    logic        fetch_freeze;
    logic        inject_nop;
    logic        push_en;
    logic        pop_en;
    logic [1:0]  stk_sel;
    logic [15:0] push_data;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        ccr_load;
    logic [2:0]  ccr_restore;

    modport master (
        output int_req, hdu_stall, branch_pending, rti_decode, pc_fetch, ccr_in, pop_data,
        input  int_ack, in_isr, fetch_freeze, inject_nop, push_en, pop_en, stk_sel,
               push_data, pc_load, pc_load_addr, ccr_load, ccr_restore
    );

    modport slave (
        input  int_req, hdu_stall, branch_pending, rti_decode, pc_fetch, ccr_in, pop_data,
        output int_ack, in_isr, fetch_freeze, inject_nop, push_en, pop_en, stk_sel,
               push_data, pc_load, pc_load_addr, ccr_load, ccr_restore
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer for the five-stage pipeline.
// Optional macro INT_SAVE_CCR_EN adds the CCR push/pop states.
module interrupt_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0020,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input logic                  clk,
    input logic                  reset,
    interrupt_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, DRAIN, PUSH_LO, PUSH_HI, PUSH_CCR, VECTOR,
        RTI_DRAIN, POP_CCR, POP_HI, POP_LO, WAIT_LO, RESUME
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        in_isr_q, in_isr_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic [15:0] hi_q, hi_d;
`ifdef INT_SAVE_CCR_EN
    logic [2:0]  saved_ccr_q, saved_ccr_d;
`endif

    logic        int_ack_q, int_ack_d;
    logic        freeze_q, freeze_d;
    logic        push_en_q, push_en_d;
    logic        pop_en_q, pop_en_d;
    logic [1:0]  stk_sel_q, stk_sel_d;
    logic [15:0] push_data_q, push_data_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] pc_load_addr_q, pc_load_addr_d;
    logic        ccr_load_q, ccr_load_d;
    logic [2:0]  ccr_restore_q, ccr_restore_d;

    logic accept;
    assign accept = pending_q && !in_isr_q && !bus.hdu_stall && !bus.branch_pending;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pending_d     = pending_q | bus.int_req;
        in_isr_d      = in_isr_q;
        saved_pc_d    = saved_pc_q;
        hi_d          = hi_q;
        ccr_restore_d = ccr_restore_q;
`ifdef INT_SAVE_CCR_EN
        saved_ccr_d   = saved_ccr_q;
`endif
        case (state_q)
            IDLE: begin
                // accept already requires !in_isr, so RTI always takes priority
                if (in_isr_q && bus.rti_decode) begin
                    state_d = RTI_DRAIN;
                    cnt_d   = 3'(DRAIN_CYCLES - 1);
                end else if (accept) begin
                    state_d    = DRAIN;
                    cnt_d      = 3'(DRAIN_CYCLES - 1);
                    pending_d  = 1'b0;
                    saved_pc_d = bus.pc_fetch;
`ifdef INT_SAVE_CCR_EN
                    saved_ccr_d = bus.ccr_in;
`endif
                end
            end
            DRAIN: begin
                if (cnt_q == 3'd0) state_d = PUSH_LO;
                else               cnt_d   = cnt_q - 3'd1;
            end
            PUSH_LO: state_d = PUSH_HI;
`ifdef INT_SAVE_CCR_EN
            PUSH_HI:  state_d = PUSH_CCR;
            PUSH_CCR: state_d = VECTOR;
`else
            PUSH_HI:  state_d = VECTOR;
`endif
            VECTOR: begin
                state_d  = IDLE;
                in_isr_d = 1'b1;
            end
            RTI_DRAIN: begin
`ifdef INT_SAVE_CCR_EN
                if (cnt_q == 3'd0) state_d = POP_CCR;
`else
                if (cnt_q == 3'd0) state_d = POP_HI;
`endif
                else               cnt_d   = cnt_q - 3'd1;
            end
`ifdef INT_SAVE_CCR_EN
            POP_CCR: state_d = POP_HI;
`endif
            // pop_data trails pop_en by one cycle, so each capture lags its pop
            POP_HI: begin
                state_d = POP_LO;
`ifdef INT_SAVE_CCR_EN
                ccr_restore_d = bus.pop_data[2:0];
`endif
            end
            POP_LO: begin
                state_d = WAIT_LO;
                hi_d    = bus.pop_data;
            end
            WAIT_LO: state_d = RESUME;
            RESUME: begin
                state_d  = IDLE;
                in_isr_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        int_ack_d      = (state_q == IDLE) && (state_d == DRAIN);
        freeze_d       = (state_d != IDLE);
        push_en_d      = 1'b0;
        pop_en_d       = 1'b0;
        stk_sel_d      = 2'd0;
        push_data_d    = 16'h0000;
        pc_load_d      = 1'b0;
        pc_load_addr_d = 32'h0000_0000;
        ccr_load_d     = 1'b0;
        case (state_d)
            PUSH_LO: begin
                push_en_d   = 1'b1;
                stk_sel_d   = 2'd0;
                push_data_d = saved_pc_q[15:0];
            end
            PUSH_HI: begin
                push_en_d   = 1'b1;
                stk_sel_d   = 2'd1;
                push_data_d = saved_pc_q[31:16];
            end
`ifdef INT_SAVE_CCR_EN
            PUSH_CCR: begin
                push_en_d   = 1'b1;
                stk_sel_d   = 2'd2;
                push_data_d = {13'b0, saved_ccr_q};
            end
            POP_CCR: begin
                pop_en_d  = 1'b1;
                stk_sel_d = 2'd2;
            end
`endif
            VECTOR: begin
                pc_load_d      = 1'b1;
                pc_load_addr_d = VECTOR_ADDR;
            end
            POP_HI: begin
                pop_en_d  = 1'b1;
                stk_sel_d = 2'd1;
            end
            POP_LO: begin
                pop_en_d  = 1'b1;
                stk_sel_d = 2'd0;
            end
            RESUME: begin
                pc_load_d      = 1'b1;
                pc_load_addr_d = {hi_q, bus.pop_data};
`ifdef INT_SAVE_CCR_EN
                ccr_load_d     = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            pending_q      <= 1'b0;
            in_isr_q       <= 1'b0;
            saved_pc_q     <= 32'h0000_0000;
            hi_q           <= 16'h0000;
            int_ack_q      <= 1'b0;
            freeze_q       <= 1'b0;
            push_en_q      <= 1'b0;
            pop_en_q       <= 1'b0;
            stk_sel_q      <= 2'd0;
            push_data_q    <= 16'h0000;
            pc_load_q      <= 1'b0;
            pc_load_addr_q <= 32'h0000_0000;
            ccr_load_q     <= 1'b0;
            ccr_restore_q  <= 3'd0;
`ifdef INT_SAVE_CCR_EN
            saved_ccr_q    <= 3'd0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            in_isr_q       <= in_isr_d;
            saved_pc_q     <= saved_pc_d;
            hi_q           <= hi_d;
            int_ack_q      <= int_ack_d;
            freeze_q       <= freeze_d;
            push_en_q      <= push_en_d;
            pop_en_q       <= pop_en_d;
            stk_sel_q      <= stk_sel_d;
            push_data_q    <= push_data_d;
            pc_load_q      <= pc_load_d;
            pc_load_addr_q <= pc_load_addr_d;
            ccr_load_q     <= ccr_load_d;
            ccr_restore_q  <= ccr_restore_d;
`ifdef INT_SAVE_CCR_EN
            saved_ccr_q    <= saved_ccr_d;
`endif
        end
    end

    assign bus.int_ack      = int_ack_q;
    assign bus.in_isr       = in_isr_q;
    assign bus.fetch_freeze = freeze_q;
    assign bus.inject_nop   = freeze_q;
    assign bus.push_en      = push_en_q;
    assign bus.pop_en       = pop_en_q;
    assign bus.stk_sel      = stk_sel_q;
    assign bus.push_data    = push_data_q;
    assign bus.pc_load      = pc_load_q;
    assign bus.pc_load_addr = pc_load_addr_q;
    assign bus.ccr_load     = ccr_load_q;
    assign bus.ccr_restore  = ccr_restore_q;

endmodule
